// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states, master ids and lock counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CPU  = 2'b01,
    S_DBG  = 2'b10
  } state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  // Wide enough for the largest allowed lock limit (255).
  localparam int unsigned LOCK_CW = 8;

endpackage

// File: rtl/mem_arbiter_lock_timer.sv
// Saturating count of debug grants taken under dbg_lock; tc_c flags that the limit is reached.
module mem_arbiter_lock_timer
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic clk,
  input  logic i_rst,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  logic [LOCK_CW-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the count never passes the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < LOCK_CW'(MAX_LOCK))) begin
      cnt_d = cnt_q + LOCK_CW'(1);
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q >= LOCK_CW'(MAX_LOCK));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU and the debug/loader port,
// with an optional debug bus lock bounded by a grant-count timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_expired
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic          lock_expired_q, lock_expired_d;
  logic          lock_tc_c, lock_clr, lock_inc, lock_hold, lock_force;
  logic          cpu_elig, dbg_elig;

  mem_arbiter_lock_timer #(
    .MAX_LOCK(MAX_LOCK)
  ) u_lock_timer (
    .clk  (clk),
    .i_rst(i_rst),
    .clr  (lock_clr),
    .inc  (lock_inc),
    .tc_c (lock_tc_c)
  );

  // Arbitration: the master granted this cycle is never eligible for the next one.
  always_comb begin
    state_d        = S_IDLE;
    last_d         = last_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_we_d       = 1'b0;
    lock_expired_d = 1'b0;

    lock_clr   = !dbg_lock || (state_q == S_CPU);
    lock_inc   = dbg_lock && (state_q == S_DBG);
    lock_hold  = dbg_lock && !lock_tc_c;
    cpu_elig   = cpu_req && (state_q != S_CPU) && !lock_hold;
    dbg_elig   = dbg_req && (state_q != S_DBG);
    lock_force = dbg_lock && lock_tc_c && cpu_elig;

    if (lock_force) begin
      state_d = S_CPU;
    end else if (cpu_elig && dbg_elig) begin
      state_d = (last_q == M_CPU) ? S_DBG : S_CPU;
    end else if (cpu_elig) begin
      state_d = S_CPU;
    end else if (dbg_elig) begin
      state_d = S_DBG;
    end

    // RAM controls are registered so they line up with the grant cycle.
    case (state_d)
      S_CPU: begin
        last_d         = M_CPU;
        mem_addr_d     = cpu_addr;
        mem_wdata_d    = cpu_wdata;
        mem_we_d       = cpu_we;
        lock_expired_d = lock_force;
      end
      S_DBG: begin
        last_d      = M_DBG;
        mem_addr_d  = dbg_addr;
        mem_wdata_d = dbg_wdata;
        mem_we_d    = dbg_we;
      end
      default: ;
    endcase

    cpu_rvalid_d = (state_q == S_CPU) && !mem_we_q;
    dbg_rvalid_d = (state_q == S_DBG) && !mem_we_q;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      last_q         <= M_CPU;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_we_q       <= 1'b0;
      cpu_rvalid_q   <= 1'b0;
      dbg_rvalid_q   <= 1'b0;
      lock_expired_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_we_q       <= mem_we_d;
      cpu_rvalid_q   <= cpu_rvalid_d;
      dbg_rvalid_q   <= dbg_rvalid_d;
      lock_expired_q <= lock_expired_d;
    end
  end

  assign cpu_gnt      = (state_q == S_CPU);
  assign dbg_gnt      = (state_q == S_DBG);
  assign cpu_rvalid   = cpu_rvalid_q;
  assign dbg_rvalid   = dbg_rvalid_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign lock_expired = lock_expired_q;
  assign rdata        = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency RAM and MAX_LOCK=4.
module tb_mem_arbiter;

  logic       clk;
  logic       i_rst;
  logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, lock_expired;

  logic       bd_we;
  logic [7:0] bd_addr, bd_data;
  logic [7:0] ram [256];

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(4)) dut (
    .clk(clk), .i_rst(i_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .lock_expired(lock_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with a backdoor write port for preload.
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
  endtask

  task automatic test_reset();
    i_rst = 1; bd_we = 0; bd_addr = 0; bd_data = 0;
    idle_inputs();
    step(); step();
    n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL reset_cpu_gnt: got %b want 0", cpu_gnt); end
    n_cmp++; if (dbg_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dbg_gnt: got %b want 0", dbg_gnt); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'h00) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
    n_cmp++; if ({cpu_rvalid, dbg_rvalid, lock_expired} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {cpu_rvalid, dbg_rvalid, lock_expired}); end
    i_rst = 0;
    step();
  endtask

  task automatic test_cpu_read();
    bd_we = 1; bd_addr = 8'h05; bd_data = 8'h2A;
    step();
    bd_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
    step();
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL cpu_read_gnt: got %b want 1", cpu_gnt); end
    n_cmp++; if (mem_addr !== 8'h05) begin n_err++; $display("FAIL cpu_read_addr: got %h want 05", mem_addr); end
    n_cmp++; if (dbg_gnt !== 1'b0) begin n_err++; $display("FAIL cpu_read_dbg_gnt: got %b want 0", dbg_gnt); end
    cpu_req = 0;
    step();
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL cpu_read_rvalid: got %b want 1", cpu_rvalid); end
    n_cmp++; if (rdata !== 8'h2A) begin n_err++; $display("FAIL cpu_read_rdata: got %h want 2a", rdata); end
    n_cmp++; if (cpu_gnt !== 1'b0 || dbg_rvalid !== 1'b0) begin
      n_err++; $display("FAIL cpu_read_after: got gnt=%b drv=%b want 0 0", cpu_gnt, dbg_rvalid); end
    step();
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL cpu_read_rvalid_once: got %b want 0", cpu_rvalid); end
  endtask

  task automatic test_simultaneous();
    logic exp_dbg;
    i_rst = 1; step(); i_rst = 0; step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_dbg = (i % 2 == 0);
      n_cmp++; if (dbg_gnt !== exp_dbg || cpu_gnt !== !exp_dbg) begin
        n_err++; $display("FAIL simul_gnt[%0d]: got cpu=%b dbg=%b want cpu=%b dbg=%b", i, cpu_gnt, dbg_gnt, !exp_dbg, exp_dbg); end
      n_cmp++; if (mem_addr !== (exp_dbg ? 8'h20 : 8'h10)) begin
        n_err++; $display("FAIL simul_addr[%0d]: got %h want %h", i, mem_addr, exp_dbg ? 8'h20 : 8'h10); end
      if (i > 0) begin
        n_cmp++; if (dbg_rvalid !== !exp_dbg || cpu_rvalid !== exp_dbg) begin
          n_err++; $display("FAIL simul_rvalid[%0d]: got cpu=%b dbg=%b", i, cpu_rvalid, dbg_rvalid); end
      end
    end
    idle_inputs();
    step(); step();
  endtask

  task automatic test_dbg_write_cpu_read();
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h03; dbg_wdata = 8'h7F;
    step();
    n_cmp++; if (dbg_gnt !== 1'b1 || mem_we !== 1'b1) begin
      n_err++; $display("FAIL dwr_gnt_we: got gnt=%b we=%b want 1 1", dbg_gnt, mem_we); end
    n_cmp++; if (mem_addr !== 8'h03 || mem_wdata !== 8'h7F) begin
      n_err++; $display("FAIL dwr_bus: got addr=%h wdata=%h want 03 7f", mem_addr, mem_wdata); end
    dbg_req = 0; dbg_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h03;
    step();
    n_cmp++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL dwr_cpu_gnt: got gnt=%b we=%b want 1 0", cpu_gnt, mem_we); end
    n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL dwr_no_wr_rvalid: got %b want 0", dbg_rvalid); end
    cpu_req = 0;
    step();
    n_cmp++; if (cpu_rvalid !== 1'b1 || rdata !== 8'h7F) begin
      n_err++; $display("FAIL dwr_cpu_rdata: got rv=%b rdata=%h want 1 7f", cpu_rvalid, rdata); end
    step();
  endtask

  task automatic test_lock_timeout();
    // 0 idle, 1 cpu, 2 dbg for each cycle after requests are raised
    int pat [10] = '{2, 0, 2, 0, 2, 0, 2, 0, 1, 2};
    dbg_lock = 1;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h40;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h50;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (cpu_gnt !== (pat[i] == 1) || dbg_gnt !== (pat[i] == 2)) begin
        n_err++; $display("FAIL lock_gnt[%0d]: got cpu=%b dbg=%b want code %0d", i, cpu_gnt, dbg_gnt, pat[i]); end
      n_cmp++; if (lock_expired !== (i == 8)) begin
        n_err++; $display("FAIL lock_expired[%0d]: got %b want %b", i, lock_expired, (i == 8)); end
    end
    idle_inputs();
    step(); step(); step();
  endtask

  task automatic test_lock_no_cpu();
    logic bad_gnt, bad_exp;
    bad_gnt = 0; bad_exp = 0;
    dbg_lock = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 8'h60;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dbg_gnt !== (i % 2 == 0) || cpu_gnt !== 1'b0) bad_gnt = 1;
      if (lock_expired !== 1'b0) bad_exp = 1;
    end
    n_cmp++; if (bad_gnt !== 1'b0) begin n_err++; $display("FAIL lock_nocpu_pattern: got deviation=%b want 0", bad_gnt); end
    n_cmp++; if (bad_exp !== 1'b0) begin n_err++; $display("FAIL lock_nocpu_expired: got %b want 0", bad_exp); end
    n_cmp++; if (dut.u_lock_timer.cnt_q !== 8'd4) begin
      n_err++; $display("FAIL lock_nocpu_sat: got %0d want 4", dut.u_lock_timer.cnt_q); end
    idle_inputs();
    step(); step();
  endtask

  task automatic test_reset_mid_access();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
    step();
    n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_gnt: got %b want 1", cpu_gnt); end
    cpu_req = 0;
    #2 i_rst = 1;
    #1;
    n_cmp++; if (cpu_gnt !== 1'b0 || mem_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_async: got gnt=%b we=%b rv=%b want 000", cpu_gnt, mem_we, cpu_rvalid); end
    step();
    i_rst = 0;
    step();
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_rvalid: got %b want 0", cpu_rvalid); end
    // Reset during a write must drop mem_we at once.
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h07; dbg_wdata = 8'h11;
    step();
    dbg_req = 0;
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL rst_wr_pre_we: got %b want 1", mem_we); end
    #2 i_rst = 1;
    #1;
    n_cmp++; if (mem_we !== 1'b0 || dbg_gnt !== 1'b0) begin
      n_err++; $display("FAIL rst_wr_async: got we=%b gnt=%b want 0 0", mem_we, dbg_gnt); end
    step();
    i_rst = 0;
    idle_inputs();
    cpu_req = 1; cpu_addr = 8'h01; dbg_req = 1; dbg_addr = 8'h02;
    step();
    n_cmp++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      n_err++; $display("FAIL rst_first_tie: got cpu=%b dbg=%b want 0 1", cpu_gnt, dbg_gnt); end
    idle_inputs();
    step(); step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_dbg_write_cpu_read();
    test_lock_timeout();
    test_lock_no_cpu();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
